// File: rtl/vfd_led_arbiter_pkg.sv
// Shared definitions for the LED bank arbiter: FSM state encoding and the
// width helper used to size the hold counter and the last-owner index.
package vfd_led_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vfd_led_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index after
// 'last' (wrapping), skipping any index set in the exclude mask.
module vfd_led_arbiter_rr_pick #(
  parameter int N_REQ = 3,
  parameter int LW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [LW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] cand;

  assign cand = req & ~excl;

  // Scan last+1, last+2, ... last+N_REQ with wrap; first candidate wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      int j;
      j = int'(last) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = LW'(j);
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/vfd_led_arbiter.sv
// Round-robin owner of the 5-LED bank with a minimum hold time counted in
// prescaler ticks, so each pattern source stays visible long enough to read.
//
// Handshake: i_req is a level request held by a source for as long as it wants
// the bank; o_gnt is the one-hot acknowledgement (zero when idle). A source owns
// the bank from the edge its o_gnt bit rises until the edge it falls; dropping
// i_req releases on the next edge regardless of hold time.
module vfd_led_arbiter
  import vfd_led_arbiter_pkg::*;
#(
  parameter int                 N_REQ        = 3,
  parameter int                 W_LED        = 5,
  parameter int                 HOLD_TICKS   = 4,
  parameter logic [W_LED-1:0]   IDLE_PATTERN = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_tick,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*W_LED-1:0] i_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_busy,
  output logic [W_LED-1:0]       o_led
);

  // A hold of zero ticks would let owners flicker; treat it as one tick.
  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int LW       = clog2_min1(N_REQ);
  localparam int HW       = clog2_min1(HOLD_EFF + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_EFF);
  localparam logic [LW-1:0] LAST_RESET = LW'(N_REQ - 1);

  arb_state_t       state, state_n;
  logic [LW-1:0]    last, last_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [N_REQ-1:0] gnt_n;
  logic [W_LED-1:0] led_n;

  logic             owner_req;
  logic             expired;
  logic             pick_found;
  logic [LW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  // 'last' always names the current owner while in OWN.
  assign owner_req = |(i_req & o_gnt);
  assign expired   = (hold_cnt == HOLD_MAX);
  assign o_busy    = |o_gnt;

  // Excluding the current grant lets one picker serve both the idle grant
  // (o_gnt is zero there) and the switch-to-another-source decision.
  vfd_led_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_pick (
    .req    (i_req),
    .last   (last),
    .excl   (o_gnt),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Next-state, next-grant, hold counter and LED selection.
  always_comb begin
    state_n = state;
    gnt_n   = o_gnt;
    last_n  = last;
    hold_n  = hold_cnt;
    case (state)
      ST_IDLE: begin
        // A tick coinciding with the grant edge is not counted.
        if (pick_found) begin
          state_n = ST_OWN;
          gnt_n   = pick_onehot;
          last_n  = pick_idx;
          hold_n  = '0;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          // Release beats hold time and swallows any coincident tick.
          hold_n = '0;
          if (pick_found) begin
            gnt_n  = pick_onehot;
            last_n = pick_idx;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
        end else if (expired && pick_found) begin
          gnt_n  = pick_onehot;
          last_n = pick_idx;
          hold_n = '0;
        end else if (i_tick && !expired) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
    led_n = (state_n == ST_OWN) ? i_data[int'(last_n)*W_LED +: W_LED] : IDLE_PATTERN;
  end

  // State, grant and LED registers; the LED changes on the same edge as the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      o_gnt    <= '0;
      last     <= LAST_RESET;
      hold_cnt <= '0;
      o_led    <= IDLE_PATTERN;
    end else begin
      state    <= state_n;
      o_gnt    <= gnt_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      o_led    <= led_n;
    end
  end

endmodule

// File: tb/tb_vfd_led_arbiter.sv
// Directed bench for the LED bank arbiter: instance a uses HOLD_TICKS=4 and a
// non-zero idle pattern, instance b uses HOLD_TICKS=0 (expected to act as 1).
module tb_vfd_led_arbiter;

  localparam int N_REQ = 3;
  localparam int W_LED = 5;
  localparam logic [W_LED-1:0] IDLE_A = 5'b10101;
  localparam logic [W_LED-1:0] IDLE_B = 5'b00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   tick_a = 1'b0, tick_b = 1'b0;
  logic [N_REQ-1:0]       req_a = '0, req_b = '0;
  logic [N_REQ*W_LED-1:0] data_a, data_b;
  logic [N_REQ-1:0]       gnt_a, gnt_b;
  logic                   busy_a, busy_b;
  logic [W_LED-1:0]       led_a, led_b;

  int n_cmp = 0;
  int n_err = 0;

  vfd_led_arbiter #(
    .N_REQ(N_REQ), .W_LED(W_LED), .HOLD_TICKS(4), .IDLE_PATTERN(IDLE_A)
  ) dut_a (
    .clk(clk), .rst(rst), .i_tick(tick_a), .i_req(req_a), .i_data(data_a),
    .o_gnt(gnt_a), .o_busy(busy_a), .o_led(led_a)
  );

  vfd_led_arbiter #(
    .N_REQ(N_REQ), .W_LED(W_LED), .HOLD_TICKS(0), .IDLE_PATTERN(IDLE_B)
  ) dut_b (
    .clk(clk), .rst(rst), .i_tick(tick_b), .i_req(req_b), .i_data(data_b),
    .o_gnt(gnt_b), .o_busy(busy_b), .o_led(led_b)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] g, input logic [4:0] l);
    chk({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    chk({tag, ".led"}, 32'(led_a), 32'(l));
    chk({tag, ".busy"}, 32'(busy_a), 32'(|g));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // sources: d0=03, d1=0C, d2=11
    data_a = {5'h11, 5'h0C, 5'h03};
    data_b = {5'h1E, 5'h09, 5'h06};
    rst = 1'b1;
    cyc(); cyc();
    chk_a("reset", 3'b000, IDLE_A);
    chk("reset_b.gnt", 32'(gnt_b), 32'd0);
    rst = 1'b0;
    cyc();
    chk_a("idle_no_req", 3'b000, IDLE_A);

    // 1: all request -> index 0 wins first
    req_a = 3'b111;
    cyc();
    chk_a("first_grant", 3'b001, 5'h03);
    // LED follows owner's data with one-cycle latency
    data_a[4:0] = 5'h07;
    chk("led_latency", 32'(led_a), 32'h03);
    cyc();
    chk_a("led_follow", 3'b001, 5'h07);
    data_a[4:0] = 5'h03;
    cyc();

    // 2: owner 0, req1 pending; switch one edge after hold saturates
    req_a = 3'b011;
    for (int k = 1; k <= 4; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      chk_a($sformatf("hold_tick%0d", k), 3'b001, 5'h03);
      if (k < 4) begin
        cyc();
        chk_a($sformatf("hold_gap%0d", k), 3'b001, 5'h03);
      end
    end
    cyc();
    chk_a("hold_switch", 3'b010, 5'h0C);

    // 4: owner 1 drops req with coincident tick, req0 pending -> 0 next edge
    req_a  = 3'b001;
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk_a("drop_with_tick", 3'b001, 5'h03);

    // 3: only req0, 10 ticks -> keeps bank; then req2 switches immediately
    for (int k = 0; k < 10; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      chk($sformatf("solo_hold%0d", k), 32'(gnt_a), 32'b001);
    end
    req_a = 3'b101;
    cyc();
    chk_a("expired_switch", 3'b100, 5'h11);

    // wrap: owner 2 drops, 0 and 1 pending -> 0 wins
    req_a = 3'b011;
    cyc();
    chk_a("wrap", 3'b001, 5'h03);

    // 5: owner drops, nobody else -> idle
    req_a = 3'b000;
    cyc();
    chk_a("release_idle", 3'b000, IDLE_A);

    // grant from idle with coincident tick: tick not counted
    req_a  = 3'b001;
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk_a("grant_tick", 3'b001, 5'h03);
    req_a = 3'b011;
    for (int k = 1; k <= 3; k++) begin
      tick_a = 1'b1;
      cyc();
      tick_a = 1'b0;
      chk($sformatf("gt_tick%0d", k), 32'(gnt_a), 32'b001);
    end
    cyc();
    chk("gt_not_expired", 32'(gnt_a), 32'b001);
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk("gt_tick4", 32'(gnt_a), 32'b001);
    cyc();
    chk_a("gt_switch", 3'b010, 5'h0C);

    // 6: rst pulsed in OWN with all requests and a tick -> reset values
    req_a  = 3'b111;
    rst    = 1'b1;
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    chk_a("rst_in_own", 3'b000, IDLE_A);
    rst = 1'b0;
    cyc();
    chk_a("after_rst", 3'b001, 5'h03);

    // HOLD_TICKS=0 behaves as 1
    req_b = 3'b011;
    cyc();
    chk("h0_grant", 32'(gnt_b), 32'b001);
    chk("h0_led", 32'(led_b), 32'h06);
    cyc();
    chk("h0_no_tick", 32'(gnt_b), 32'b001);
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    chk("h0_tick", 32'(gnt_b), 32'b001);
    cyc();
    chk("h0_switch", 32'(gnt_b), 32'b010);
    chk("h0_switch_led", 32'(led_b), 32'h09);
    req_b = 3'b000;
    cyc();
    chk("h0_idle", 32'(gnt_b), 32'b000);
    chk("h0_idle_led", 32'(led_b), 32'(IDLE_B));

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
